// File: rtl/mux_2_1.sv
// mux_2_1: parameterizable 2:1 multiplexer with an optional output register.
//
// Parameters
//   WIDTH   : bit width of in0, in1 and res
//   REG_OUT : 1 -> res is registered with 1-cycle latency
//             0 -> res is combinational; clk and rst_n are ignored
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the output register
//   in0   : data selected when sel = 0
//   in1   : data selected when sel = 1
//   sel   : select
//   res   : selected data
module mux_2_1 #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] mux_next;

  assign mux_next = sel ? in1 : in0;

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] res_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else begin
          res_q <= mux_next;
        end
      end

      assign res = res_q;
    end else begin : g_comb
      // clk and rst_n have no function in the combinational variant;
      // fold them into a deliberately unused net so the ports stay visible.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};

      assign res = mux_next;
    end
  endgenerate

endmodule

// File: tb/tb_mux_2_1.sv
// Bench for mux_2_1: one registered and one combinational instance.
// Registered path uses a scoreboard queue filled by the driver and drained
// by a monitor one edge later; combinational path is checked in place.
module tb_mux_2_1;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in0_r, in1_r, res_r;
  logic         sel_r;
  logic [W-1:0] in0_c, in1_c, res_c;
  logic         sel_c;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  mux_2_1 #(.WIDTH(W), .REG_OUT(1)) dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .in0   (in0_r),
    .in1   (in1_r),
    .sel   (sel_r),
    .res   (res_r)
  );

  mux_2_1 #(.WIDTH(W), .REG_OUT(0)) dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .in0   (in0_c),
    .in1   (in1_c),
    .sel   (sel_c),
    .res   (res_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick element sel out of the pair of inputs.
  function automatic logic [W-1:0] pick(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic s);
    logic [W-1:0] pair [2];
    pair[0] = a;
    pair[1] = b;
    return pair[int'(s)];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive the registered DUT away from the active edge and queue the
  // value it must show after the next rising edge.
  task automatic drive_r(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    in0_r = a;
    in1_r = b;
    sel_r = s;
    exp_q.push_back(pick(a, b, s));
  endtask

  task automatic drive_c(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input string name);
    in0_c = a;
    in1_c = b;
    sel_c = s;
    #1;
    check(name, res_c, pick(a, b, s));
  endtask

  // Monitor: registered output is presented one cycle after capture.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("reg_out", res_r, e);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    in0_r = '0; in1_r = '0; sel_r = 1'b0;
    in0_c = '0; in1_c = '0; sel_c = 1'b0;

    // Asynchronous reset before any clock edge (first posedge is at 5).
    #1;
    in0_r = 8'h01; in1_r = 8'h01; sel_r = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_async", res_r, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", res_r, '0);

    // Release reset; first capture on the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(pick(8'h01, 8'h01, 1'b1));

    // sel=0 path
    drive_r(8'h00, 8'h01, 1'b0);
    drive_r(8'h01, 8'h00, 1'b0);
    // sel=1 path
    drive_r(8'h01, 8'h00, 1'b1);
    drive_r(8'h00, 8'h01, 1'b1);
    // Equal inputs
    drive_r(8'h01, 8'h01, 1'b0);
    drive_r(8'h00, 8'h00, 1'b1);
    // Simultaneous change of sel and data
    drive_r(8'h00, 8'h01, 1'b0);
    drive_r(8'h01, 8'h00, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      drive_r(W'($urandom), W'($urandom), 1'($urandom));
    end

    // Bring res to 1, then reset mid-cycle.
    drive_r(8'h00, 8'h01, 1'b1);
    @(posedge clk);
    #3;
    check("pre_mid_reset", res_r, 8'h01);
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", res_r, '0);

    // Combinational instance: no clock edge between changes, reset active.
    @(negedge clk);
    #1;
    drive_c(8'hA5, 8'h5A, 1'b0, "comb_sel0_in_reset");
    drive_c(8'hA5, 8'h5A, 1'b1, "comb_sel1_in_reset");
    drive_c(8'h3C, 8'h3C, 1'b0, "comb_equal");
    check("reg_still_reset", res_r, '0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 50; i++) begin
      drive_c(W'($urandom), W'($urandom), 1'($urandom), "comb_rand");
    end

    // Drain scoreboard
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
